// File: rtl/dmem_portb_arbiter.sv
// Port-B arbiter for the data memory: round-robin over NUM_CH masters with burst lock, 1-cycle registered RAM issue,
// read tags returned T+1+RD_LAT; a master holds req until gnt. Build option DMEM_ARB_CH0_PRIORITY_EN gives channel 0 strict priority.
module dmem_portb_arbiter #(
   parameter int NUM_CH   = 2,
   parameter int DATA_W   = 256,
   parameter int ADDR_W   = 7,
   parameter int RD_LAT   = 2,
   parameter int MAX_LOCK = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH-1:0]        lock,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        gnt,
   output logic [NUM_CH-1:0]        rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   output logic                     ram_wren,
   output logic                     ram_rden,
   input  logic [DATA_W-1:0]        ram_q
);

   localparam int PTR_W = $clog2(NUM_CH);
   localparam int CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 16;

   logic [PTR_W-1:0]  r_ptr;
   logic              r_lock_vld;
   logic [PTR_W-1:0]  r_lock_own;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic              r_excl_vld;
   logic [PTR_W-1:0]  r_excl_ch;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_ram_wren;
   logic              r_ram_rden;
   logic [NUM_CH-1:0] r_tag [RD_LAT+1];

   logic [NUM_CH-1:0] w_excl_mask;
   logic [NUM_CH-1:0] w_req_m;
   logic [NUM_CH-1:0] w_gnt;
   logic [PTR_W-1:0]  w_sel;
   logic              w_found;
   logic              w_pre;
   logic              w_hold;
   logic              w_acc;
   logic              w_ptr_upd;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_cnt_max;
   logic [ADDR_W-1:0] w_addr_sel;
   logic [DATA_W-1:0] w_wdata_sel;
   logic              w_we_sel;

   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      return PTR_W'(s);
   endfunction

   // A channel that just exhausted its lock budget sits out one round, but only if someone else is waiting.
   always_comb begin
      w_excl_mask = '0;
      if (r_excl_vld) w_excl_mask[r_excl_ch] = 1'b1;
      w_req_m = req;
      if (|(req & ~w_excl_mask)) w_req_m = req & ~w_excl_mask;
   end

`ifdef DMEM_ARB_CH0_PRIORITY_EN
   assign w_pre     = req[0] & r_lock_vld & (r_lock_own != '0);
   assign w_ptr_upd = w_acc & (w_sel != '0);
`else
   assign w_pre     = 1'b0;
   assign w_ptr_upd = w_acc;
`endif

   assign w_hold = r_lock_vld & req[r_lock_own] & lock[r_lock_own] & ~w_pre;

   always_comb begin
      w_gnt   = '0;
      w_sel   = r_ptr;
      w_found = 1'b0;
      if (w_hold) begin
         w_gnt[r_lock_own] = 1'b1;
         w_sel             = r_lock_own;
      end
`ifdef DMEM_ARB_CH0_PRIORITY_EN
      else if (w_req_m[0]) begin
         w_gnt[0] = 1'b1;
         w_sel    = '0;
      end
`endif
      else begin
         for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && w_req_m[f_wrap(r_ptr, k)]) begin
               w_found                 = 1'b1;
               w_gnt[f_wrap(r_ptr, k)] = 1'b1;
               w_sel                   = f_wrap(r_ptr, k);
            end
         end
      end
   end

   assign gnt   = w_gnt;
   assign w_acc = |(req & w_gnt);

   always_comb begin
      w_addr_sel  = '0;
      w_wdata_sel = '0;
      w_we_sel    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gnt[i]) begin
            w_addr_sel  = addr[i*ADDR_W +: ADDR_W];
            w_wdata_sel = wdata[i*DATA_W +: DATA_W];
            w_we_sel    = we[i];
         end
      end
   end

   // Count of locked beats including the one being accepted now; saturates when unlimited.
   always_comb begin
      w_cnt_next = CNT_W'(1);
      if (w_hold) w_cnt_next = (&r_lock_cnt) ? r_lock_cnt : r_lock_cnt + 1'b1;
      w_cnt_max = (MAX_LOCK != 0) && (int'(w_cnt_next) >= MAX_LOCK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= PTR_W'(NUM_CH - 1);
         r_lock_vld <= 1'b0;
         r_lock_own <= '0;
         r_lock_cnt <= '0;
         r_excl_vld <= 1'b0;
         r_excl_ch  <= '0;
      end else begin
         if (w_ptr_upd) r_ptr <= w_sel;
         if (w_acc) begin
            r_excl_vld <= 1'b0;
            if (lock[w_sel] && !w_cnt_max) begin
               r_lock_vld <= 1'b1;
               r_lock_own <= w_sel;
               r_lock_cnt <= w_cnt_next;
            end else begin
               r_lock_vld <= 1'b0;
               r_lock_cnt <= '0;
               if (lock[w_sel]) begin
                  r_excl_vld <= 1'b1;
                  r_excl_ch  <= w_sel;
               end
            end
         end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_wren  <= 1'b0;
         r_ram_rden  <= 1'b0;
      end else begin
         r_ram_wren <= w_acc & w_we_sel;
         r_ram_rden <= w_acc & ~w_we_sel;
         if (w_acc) begin
            r_ram_addr  <= w_addr_sel;
            r_ram_wdata <= w_wdata_sel;
         end
      end
   end

   // Stage 0 lines up with ram_rden; the last stage lines up with ram_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s <= RD_LAT; s++) r_tag[s] <= '0;
      end else begin
         r_tag[0] <= (w_acc && !w_we_sel) ? w_gnt : '0;
         for (int s = 1; s <= RD_LAT; s++) r_tag[s] <= r_tag[s-1];
      end
   end

   assign rvalid    = r_tag[RD_LAT];
   assign rdata     = ram_q;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign ram_wren  = r_ram_wren;
   assign ram_rden  = r_ram_rden;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter: stimulus table plus multi-cycle sequences, RAM model, read-return scoreboard.
module tb_dmem_portb_arbiter;
   localparam int NUM_CH   = 2;
   localparam int DATA_W   = 256;
   localparam int ADDR_W   = 7;
   localparam int RD_LAT   = 2;
   localparam int MAX_LOCK = 16;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_CH-1:0]        req, we, lock, gnt, rvalid;
   logic [NUM_CH*ADDR_W-1:0] addr;
   logic [NUM_CH*DATA_W-1:0] wdata;
   logic [DATA_W-1:0]        rdata, ram_wdata, ram_q;
   logic [ADDR_W-1:0]        ram_addr;
   logic                     ram_wren, ram_rden;

   always #5 clk = ~clk;

   dmem_portb_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
   );

   function automatic logic [DATA_W-1:0] init_word(input int a);
      return {8{32'hC0DE0000 | 32'(a)}};
   endfunction

   // RAM model: write-before-read across cycles, RD_LAT cycles from rden to q.
   logic [DATA_W-1:0] mem [128];
   bit                wr_seen [128];
   logic [DATA_W-1:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (ram_wren) begin
         mem[ram_addr]     <= ram_wdata;
         wr_seen[ram_addr] <= 1'b1;
      end
      pipe[0] <= wr_seen[ram_addr] ? mem[ram_addr] : init_word(int'(ram_addr));
      for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
   end
   assign ram_q = pipe[RD_LAT-1];

   int n_chk = 0;
   int n_err = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      int                ch;
      logic [DATA_W-1:0] dat;
      int                due;
   } sb_t;
   sb_t sbq[$];

   logic [DATA_W-1:0] shadow [128];
   logic              exp_wr, exp_rd;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wd;

   always @(negedge clk) begin : mon
      sb_t e;
      if (rst_n) begin
         if (rvalid != '0) begin
            if (sbq.size() == 0) chk("rvalid_unexpected", rvalid, 0);
            else begin
               e = sbq.pop_front();
               chk("rvalid_ch", rvalid, 1 << e.ch);
               chk("rvalid_cycle", cyc_n, e.due);
               chk("rdata", rdata, e.dat);
            end
         end else if (sbq.size() != 0 && sbq[0].due <= cyc_n) begin
            e = sbq.pop_front();
            chk("rvalid_missing", rvalid, 1 << e.ch);
         end
      end
   end

   // One cycle: drive at posedge+1, check gnt, predict the issue, check registered RAM side after the edge.
   task automatic cyc(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                      input logic [6:0] a0, input logic [6:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] eg, input string nm);
      int                ch;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      req = rq; we = w; lock = lk; addr = {a1, a0}; wdata = {{8{d1}}, {8{d0}}};
      #1;
      chk({nm, "_gnt"}, gnt, eg);
      if (eg != 2'b00) begin
         ch = eg[1] ? 1 : 0;
         ea = (ch == 1) ? a1 : a0;
         ed = (ch == 1) ? {8{d1}} : {8{d0}};
         exp_wr = w[ch]; exp_rd = !w[ch]; exp_addr = ea; exp_wd = ed;
         if (w[ch]) shadow[ea] = ed;
         else sbq.push_back('{ch, shadow[ea], cyc_n + 1 + RD_LAT});
      end else begin
         exp_wr = 1'b0; exp_rd = 1'b0;
      end
      @(posedge clk); #1;
      chk({nm, "_wren"}, ram_wren, exp_wr);
      chk({nm, "_rden"}, ram_rden, exp_rd);
      chk({nm, "_addr"}, ram_addr, exp_addr);
      chk({nm, "_wdata"}, ram_wdata, exp_wd);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 2'b00, nm);
   endtask

   typedef struct {
      logic [1:0]  rq, w, lk;
      logic [6:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [1:0]  eg, egp;
   } vec_t;
   vec_t tv [16];

   initial begin : main
      logic [1:0] eg;
      tv[0]  = '{2'b11, 2'b00, 2'b00, 7'd1,  7'd2,  32'h0,        32'h0,        2'b01, 2'b01};
      tv[1]  = '{2'b11, 2'b00, 2'b00, 7'd1,  7'd2,  32'h0,        32'h0,        2'b10, 2'b01};
      tv[2]  = '{2'b11, 2'b00, 2'b00, 7'd1,  7'd2,  32'h0,        32'h0,        2'b01, 2'b01};
      tv[3]  = '{2'b11, 2'b00, 2'b00, 7'd1,  7'd2,  32'h0,        32'h0,        2'b10, 2'b01};
      tv[4]  = '{2'b00, 2'b00, 2'b00, 7'd0,  7'd0,  32'h0,        32'h0,        2'b00, 2'b00};
      tv[5]  = '{2'b01, 2'b01, 2'b00, 7'd5,  7'd0,  32'hA5A5A5A5, 32'h0,        2'b01, 2'b01};
      tv[6]  = '{2'b10, 2'b00, 2'b00, 7'd0,  7'd5,  32'h0,        32'h0,        2'b10, 2'b10};
      tv[7]  = '{2'b10, 2'b10, 2'b00, 7'd0,  7'd9,  32'h0,        32'h3C3C3C3C, 2'b10, 2'b10};
      tv[8]  = '{2'b01, 2'b00, 2'b00, 7'd9,  7'd0,  32'h0,        32'h0,        2'b01, 2'b01};
      tv[9]  = '{2'b11, 2'b10, 2'b00, 7'd7,  7'd12, 32'h0,        32'h5A5A0F0F, 2'b10, 2'b01};
      tv[10] = '{2'b11, 2'b10, 2'b00, 7'd12, 7'd13, 32'h0,        32'h11112222, 2'b01, 2'b01};
      tv[11] = '{2'b11, 2'b01, 2'b00, 7'd14, 7'd12, 32'h77778888, 32'h0,        2'b10, 2'b01};
      tv[12] = '{2'b11, 2'b01, 2'b00, 7'd14, 7'd14, 32'h77778888, 32'h0,        2'b01, 2'b01};
      tv[13] = '{2'b11, 2'b00, 2'b00, 7'd14, 7'd14, 32'h0,        32'h0,        2'b10, 2'b01};
      tv[14] = '{2'b00, 2'b00, 2'b00, 7'd0,  7'd0,  32'h0,        32'h0,        2'b00, 2'b00};
      tv[15] = '{2'b00, 2'b00, 2'b00, 7'd0,  7'd0,  32'h0,        32'h0,        2'b00, 2'b00};

      for (int a = 0; a < 128; a++) shadow[a] = init_word(a);
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
      exp_addr = '0; exp_wd = '0;

      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_rden", ram_rden, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_rvalid", rvalid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
`ifdef DMEM_ARB_CH0_PRIORITY_EN
         eg = tv[i].egp;
`else
         eg = tv[i].eg;
`endif
         cyc(tv[i].rq, tv[i].w, tv[i].lk, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1, eg, $sformatf("vec%0d", i));
      end
      idle(4, "drain1");

`ifndef DMEM_ARB_CH0_PRIORITY_EN
      // Lock budget: ch1 owns 16 beats, ch0 gets beat 17, ch1 comes back.
      cyc(2'b10, 2'b00, 2'b10, 7'd4, 7'd3, 32'h0, 32'h0, 2'b10, "lk_b1");
      for (int b = 2; b <= 16; b++)
         cyc(2'b11, 2'b00, 2'b10, 7'd4, 7'd3, 32'h0, 32'h0, 2'b10, $sformatf("lk_b%0d", b));
      cyc(2'b11, 2'b00, 2'b10, 7'd4, 7'd3, 32'h0, 32'h0, 2'b01, "lk_b17");
      for (int b = 18; b <= 20; b++)
         cyc(2'b11, 2'b00, 2'b10, 7'd4, 7'd3, 32'h0, 32'h0, 2'b10, $sformatf("lk_b%0d", b));
      idle(1, "lk_rel");

      // Short ch0 burst, lock dropped while ch1 waits.
      for (int b = 0; b < 3; b++)
         cyc(2'b11, 2'b00, 2'b01, 7'd30, 7'd31, 32'h0, 32'h0, 2'b01, $sformatf("bu_b%0d", b));
      cyc(2'b11, 2'b00, 2'b00, 7'd30, 7'd31, 32'h0, 32'h0, 2'b10, "bu_drop");
      chk("bu_cnt_zero", dut.r_lock_cnt, 0);
      cyc(2'b11, 2'b00, 2'b00, 7'd30, 7'd31, 32'h0, 32'h0, 2'b01, "bu_after");
      idle(4, "drain2");
`else
      // Channel 0 cuts into a ch1 lock.
      for (int b = 0; b < 3; b++)
         cyc(2'b10, 2'b00, 2'b10, 7'd40, 7'd41, 32'h0, 32'h0, 2'b10, $sformatf("pr_b%0d", b));
      cyc(2'b11, 2'b00, 2'b10, 7'd40, 7'd41, 32'h0, 32'h0, 2'b01, "pr_pre");
      chk("pr_lock_released", dut.r_lock_vld, 0);
      cyc(2'b10, 2'b00, 2'b10, 7'd40, 7'd41, 32'h0, 32'h0, 2'b10, "pr_back");
      idle(4, "drain2");
`endif

      // Reset with two reads in flight.
      cyc(2'b01, 2'b00, 2'b00, 7'd20, 7'd21, 32'h0, 32'h0, 2'b01, "rs_rd0");
      cyc(2'b10, 2'b00, 2'b00, 7'd20, 7'd21, 32'h0, 32'h0, 2'b10, "rs_rd1");
      req = '0;
      #2 rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("rs_wren", ram_wren, 0);
      chk("rs_rden", ram_rden, 0);
      chk("rs_addr", ram_addr, 0);
      chk("rs_wdata", ram_wdata, 0);
      chk("rs_rvalid", rvalid, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      exp_addr = '0; exp_wd = '0;
      idle(5, "rs_quiet");
      cyc(2'b11, 2'b00, 2'b00, 7'd22, 7'd23, 32'h0, 32'h0, 2'b01, "rs_first");
`ifdef DMEM_ARB_CH0_PRIORITY_EN
      cyc(2'b11, 2'b00, 2'b00, 7'd22, 7'd23, 32'h0, 32'h0, 2'b01, "rs_second");
`else
      cyc(2'b11, 2'b00, 2'b00, 7'd22, 7'd23, 32'h0, 32'h0, 2'b10, "rs_second");
`endif
      idle(5, "drain3");
      if (sbq.size() != 0) chk("sb_leftover", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_portb_arbiter.md
Name: dmem_portb_arbiter

Overview:
Parametrised N-channel arbiter for the shared port B of the data memory. Today port B is wired directly to the CCD row writer. This block lets the CCD row writer, the NN accelerator and any future DMA masters each issue reads and writes to port B. It provides round-robin arbitration, optional burst locking, a registered RAM-side interface, and per-channel read-return tagging that accounts for the RAM read latency.

Parameters:
NUM_CH, 2, number of requesting channels (2..8); channel 0 = CCD, channel 1 = accelerator
DATA_W, 256, port-B data width in bits
ADDR_W, 7, port-B word address width
RD_LAT, 2, cycles from ram_rden asserted to ram_q valid (1..4)
MAX_LOCK, 16, maximum consecutive beats one locked channel may hold the grant; 0 = unlimited

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CH  per-channel request
we  in  NUM_CH  per-channel write enable (1 = write, 0 = read); valid with req
lock  in  NUM_CH  per-channel burst lock; valid with req
addr  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CH*DATA_W  flattened write data; same slicing rule
gnt  out  NUM_CH  one-hot grant (combinational); a transfer is accepted when req[i] & gnt[i]
rvalid  out  NUM_CH  one-hot read-data-valid, one pulse per accepted read
rdata  out  DATA_W  read data; valid where rvalid is nonzero
ram_addr  out  ADDR_W  registered RAM address
ram_wdata  out  DATA_W  registered RAM write data
ram_wren  out  1  registered RAM write enable
ram_rden  out  1  registered RAM read enable
ram_q  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ram_addr, ram_wdata, ram_wren and ram_rden are all 0.
  - The rvalid pipeline is cleared, so rvalid = 0.
  - The round-robin pointer is set to NUM_CH-1, so channel 0 wins first.
  - The lock owner is cleared and the lock counter is 0.
- Arbitration:
  - gnt is combinational from req and state.
  - At most one gnt bit is set; gnt = 0 when req = 0.
  - Round-robin: the grant goes to the first requesting channel after the pointer, wrapping modulo NUM_CH.
  - On acceptance the pointer is updated to the granted channel. With no acceptance the pointer holds.
- Lock:
  - An accepted beat with lock[i]=1 makes channel i the owner.
  - While the owner keeps req[i]=1, it is granted regardless of others, and the lock counter increments per accepted beat.
  - Ownership is released when any of these occurs:
    - req[i]=0 or lock[i]=0 in a cycle;
    - the counter reaches MAX_LOCK (when MAX_LOCK≠0). The beat that reaches MAX_LOCK is granted. In the next cycle the owner is excluded for one arbitration round if any other channel requests.
  - On release the counter is cleared to 0.
- Issue (cycle T accept, cycle T+1 RAM):
  - ram_wren = we_sel and ram_rden = ~we_sel.
  - ram_addr and ram_wdata are taken from the granted channel.
  - With no acceptance, ram_wren = ram_rden = 0 and ram_addr/ram_wdata hold their previous values.
- Read return:
  - An accepted read in cycle T sets rvalid[i] = 1 in cycle T+1+RAD_LAT, i.e. T+1+RD_LAT (tag shift register of depth RD_LAT+1).
  - rdata = ram_q, passed through combinationally.
  - Back-to-back reads return in issue order, one per cycle, with no bubbles.
- Ordering:
  - One transfer issues per cycle.
  - A write followed by a read of the same address, from any channels, returns the new data (the RAM has write-before-read ordering across cycles).
- Reset asserted mid-burst or with reads in flight: in-flight rvalid pulses are dropped and never emitted after reset release.
- A request whose addr or data change while not granted is legal; only values present in the accept cycle matter.

Optional Feature:
DMEM_ARB_CH0_PRIORITY_EN:
- When defined, channel 0 (CCD) has strict priority over all others.
  - It preempts a held lock at the next beat boundary, and the lock is released.
  - The remaining channels arbitrate round-robin among themselves.
- When undefined, all channels, channel 0 included, are pure round-robin subject to lock.

Test Plan:
1. Reset, then NUM_CH=2, req=2'b11, we=0, lock=0 held 4 cycles -> gnt sequence 01,10,01,10; ram_rden=1 from cycle 2; rvalid sequence 01,10,01,10 starting 3 cycles after first accept (RD_LAT=2).
2. Ch0 writes addr 5 data 0xA5.., next cycle ch1 reads addr 5 -> ram_wren then ram_rden at addr 5; rvalid=10 with rdata=0xA5..
3. Ch1 lock=1 req=1 for 20 beats, ch0 req=1 constantly, MAX_LOCK=16 -> ch1 granted 16 consecutive beats, ch0 granted beat 17, ch1 regains after.
4. Ch0 lock burst of 3 beats then drops lock while ch1 requests -> ch1 granted on the cycle after lock drop; lock counter back to 0.
5. Assert rst_n=0 with 2 reads in flight -> all ram_* and rvalid at 0 immediately; no rvalid after release; first grant after reset = channel 0.
6. DMEM_ARB_CH0_PRIORITY_EN defined, ch1 locked burst, ch0 raises req mid-burst -> ch0 granted next cycle; ch1 lock released.
